// File: rtl/contador_salidas_if.sv
// ---------------------------------------------------------------------------
// contador_salidas_if
//   Groups the FIFO-side and readback-side signals of contador_salidas.
//
//   FIFO side : fifo4..7_empty / fifo4..7_out (head word) from the FIFOs,
//               pop4..7 strobes back to them.
//   Readback  : req / idx from the reader, data / valid back to it.
//
//   modport slave  : the counter block (consumes FIFO flags, drives pops).
//   modport master : whoever owns the FIFOs and issues readback requests.
// ---------------------------------------------------------------------------
interface contador_salidas_if #(
    parameter int CNT_W  = 5,
    parameter int DATA_W = 10
);
    logic              fifo4_empty;
    logic              fifo5_empty;
    logic              fifo6_empty;
    logic              fifo7_empty;
    logic [DATA_W-1:0] fifo4_out;
    logic [DATA_W-1:0] fifo5_out;
    logic [DATA_W-1:0] fifo6_out;
    logic [DATA_W-1:0] fifo7_out;
    logic              pop4;
    logic              pop5;
    logic              pop6;
    logic              pop7;
    logic              req;
    logic [1:0]        idx;
    logic [CNT_W-1:0]  data;
    logic              valid;

    modport slave (
        input  fifo4_empty, fifo5_empty, fifo6_empty, fifo7_empty,
        input  fifo4_out, fifo5_out, fifo6_out, fifo7_out,
        input  req, idx,
        output pop4, pop5, pop6, pop7,
        output data, valid
    );

    modport master (
        output fifo4_empty, fifo5_empty, fifo6_empty, fifo7_empty,
        output fifo4_out, fifo5_out, fifo6_out, fifo7_out,
        output req, idx,
        input  pop4, pop5, pop6, pop7,
        input  data, valid
    );
endinterface

// File: rtl/contador_salidas.sv
// ---------------------------------------------------------------------------
// contador_salidas
//   Drains the four output FIFOs (FIFO4..FIFO7) with a round-robin pop
//   scheduler, counts delivered words per port (saturating), and after the
//   run exposes the counts through a req/valid readback.
//
//   Ports:
//     clk      : single clock, rising edge
//     reset    : synchronous, active-high; returns to INIT from any state
//     enable   : starts a run from IDLE
//     idle     : upstream finished; drain and go to DONE
//     bus      : contador_salidas_if.slave (FIFO flags/words, pops, readback)
//     err_cnt  : destination-mismatch count (0 unless CONTADOR_CHECK_EN)
//     done     : high while in DONE (one cycle after the state enters DONE)
//
//   Optional feature: define CONTADOR_CHECK_EN to compare bits [DATA_W-1 -: 2]
//   of every sampled word against the port index and count mismatches.
// ---------------------------------------------------------------------------
module contador_salidas #(
    parameter int CNT_W  = 5,
    parameter int DATA_W = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  idle,
    contador_salidas_if.slave     bus,
    output logic [CNT_W-1:0]      err_cnt,
    output logic                  done
);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [1:0]       rr_q, rr_d;
    logic [3:0]       pop_q, pop_d;
    logic [CNT_W-1:0] data_q;
    logic             valid_q;
    logic             done_q;

    logic [3:0]       empty_w;
    logic [3:0]       cand_w;
    logic [CNT_W-1:0] cnt_all [4];
    logic             sel_found;
    logic [1:0]       sel_idx;
    logic [1:0]       cand_idx;
    logic             rd_fire;
    logic             clear_cnt;

    assign empty_w = {bus.fifo7_empty, bus.fifo6_empty, bus.fifo5_empty, bus.fifo4_empty};

    // A port whose pop is currently on the wire still shows the word being
    // removed in its empty flag, so it is not eligible this cycle.
    assign cand_w = ~empty_w & ~pop_q;

    // Counters are only live during ACTIVE/DONE; INIT and IDLE hold them at 0.
    assign clear_cnt = (state_q == ST_INIT) || (state_q == ST_IDLE);

    // Round-robin pick: first eligible port starting at rr_q.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_q;
        cand_idx  = rr_q;
        for (int k = 0; k < 4; k++) begin
            cand_idx = rr_q + k[1:0];
            if (!sel_found && cand_w[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        pop_d   = 4'b0000;
        case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // Drain is complete only when nothing is queued and the last
                // popped word has already been sampled.
                if (idle && (&empty_w) && (pop_q == 4'b0000)) begin
                    state_d = ST_DONE;
                end else if (sel_found) begin
                    pop_d[sel_idx] = 1'b1;
                    rr_d           = sel_idx + 2'd1;
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    assign rd_fire = bus.req && (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            rr_q    <= 2'd0;
            pop_q   <= 4'b0000;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            pop_q   <= pop_d;
            done_q  <= (state_q == ST_DONE);
            valid_q <= rd_fire;
            if (rd_fire) begin
                data_q <= cnt_all[bus.idx];
            end
        end
    end

    // Per-port word counters: the word of a pop on the wire is taken at the
    // same edge that retires the pop in the FIFO.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            always_ff @(posedge clk) begin
                if (reset || clear_cnt) begin
                    cnt_q <= '0;
                end else if (pop_q[gi] && (cnt_q != CNT_MAX)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            assign cnt_all[gi] = cnt_q;
        end
    endgenerate

`ifdef CONTADOR_CHECK_EN
    logic [DATA_W-1:0] out_w [4];
    logic [3:0]        mis_w;
    logic [CNT_W-1:0]  err_q;

    assign out_w[0] = bus.fifo4_out;
    assign out_w[1] = bus.fifo5_out;
    assign out_w[2] = bus.fifo6_out;
    assign out_w[3] = bus.fifo7_out;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_chk
            assign mis_w[gi] = pop_q[gi] && (out_w[gi][DATA_W-1 -: 2] != 2'(gi));
        end
    endgenerate

    // At most one pop per cycle, so at most one mismatch per edge.
    always_ff @(posedge clk) begin
        if (reset || clear_cnt) begin
            err_q <= '0;
        end else if ((|mis_w) && (err_q != CNT_MAX)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

    assign bus.pop4  = pop_q[0];
    assign bus.pop5  = pop_q[1];
    assign bus.pop6  = pop_q[2];
    assign bus.pop7  = pop_q[3];
    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_contador_salidas.sv
// ---------------------------------------------------------------------------
// tb_contador_salidas
//   Random and directed runs of contador_salidas. The FIFOs are modelled as
//   queues; the expected counts are simply the number of words loaded per
//   port (saturated), and the expected error count is the number of loaded
//   words whose destination field differs from the port (saturated, only
//   when CONTADOR_CHECK_EN is defined).
// ---------------------------------------------------------------------------
module tb_contador_salidas;

    localparam int CNT_W  = 5;
    localparam int DATA_W = 10;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             idle;
    logic [CNT_W-1:0] err_cnt;
    logic             done;

    contador_salidas_if #(.CNT_W(CNT_W), .DATA_W(DATA_W)) bus ();

    contador_salidas #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .idle    (idle),
        .bus     (bus),
        .err_cnt (err_cnt),
        .done    (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] fq [4][$];
    int                exp_words [4];
    int                exp_mism;
    int                pop_cnt [4];
    int                pop_log [$];
    logic [3:0]        mon_pops;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        bus.fifo4_empty = (fq[0].size() == 0);
        bus.fifo5_empty = (fq[1].size() == 0);
        bus.fifo6_empty = (fq[2].size() == 0);
        bus.fifo7_empty = (fq[3].size() == 0);
        bus.fifo4_out   = (fq[0].size() != 0) ? fq[0][0] : '0;
        bus.fifo5_out   = (fq[1].size() != 0) ? fq[1][0] : '0;
        bus.fifo6_out   = (fq[2].size() != 0) ? fq[2][0] : '0;
        bus.fifo7_out   = (fq[3].size() != 0) ? fq[3][0] : '0;
    endtask

    // FIFO model + pop monitor: pops retire words at the rising edge.
    always begin
        @(posedge clk);
        mon_pops = {bus.pop7, bus.pop6, bus.pop5, bus.pop4};
        if (done) check_eq("pop_in_done", {28'd0, mon_pops}, 32'd0);
        if (mon_pops != 4'b0000) begin
            check_eq("pop_onehot", $countones(mon_pops), 1);
            for (int k = 0; k < 4; k++) begin
                if (mon_pops[k]) begin
                    check_eq("underflow", {31'd0, fq[k].size() > 0}, 1);
                    if (fq[k].size() > 0) void'(fq[k].pop_front());
                    pop_cnt[k]++;
                    pop_log.push_back(k);
                end
            end
        end
        #1 refresh();
    end

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    function automatic int exp_err();
`ifdef CONTADOR_CHECK_EN
        return sat(exp_mism);
`else
        return 0;
`endif
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            fq[k].delete();
            exp_words[k] = 0;
            pop_cnt[k]   = 0;
        end
        exp_mism = 0;
        pop_log.delete();
        refresh();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; idle = 1'b0; bus.req = 1'b0; bus.idx = 2'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    task automatic push_word(input int port, input logic [DATA_W-1:0] w);
        fq[port].push_back(w);
        exp_words[port]++;
        if (int'(w[DATA_W-1 -: 2]) != port) exp_mism++;
        refresh();
    endtask

    task automatic load(input int port, input int n, input int bad_pct);
        logic [1:0] dest;
        logic [7:0] low;
        for (int i = 0; i < n; i++) begin
            dest = 2'(port);
            if (int'($urandom_range(0, 99)) < bad_pct) dest = 2'($urandom_range(0, 3));
            low = 8'($urandom);
            push_word(port, {dest, low});
        end
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_timeout", {31'd0, done}, 1);
    endtask

    task automatic read_one(input int k);
        @(negedge clk);
        bus.req = 1'b1; bus.idx = 2'(k);
        @(posedge clk); #1;
        $display("read idx=%0d data=%0d valid=%0d", k, bus.data, bus.valid);
        check_eq("rd_valid", {31'd0, bus.valid}, 1);
        check_eq("rd_data", {27'd0, bus.data}, sat(exp_words[k]));
        @(negedge clk);
        bus.req = 1'b0;
        @(posedge clk); #1;
        check_eq("rd_valid_drop", {31'd0, bus.valid}, 0);
    endtask

    task automatic read_all();
        for (int k = 0; k < 4; k++) read_one(k);
        check_eq("err_cnt", {27'd0, err_cnt}, exp_err());
        for (int k = 0; k < 4; k++) check_eq("pops_per_port", pop_cnt[k], exp_words[k]);
    endtask

    // Back-to-back reads: req held for three cycles, idx 0,1,2.
    task automatic read_b2b();
        @(negedge clk);
        bus.req = 1'b1; bus.idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            $display("b2b read idx=%0d data=%0d valid=%0d", k, bus.data, bus.valid);
            check_eq("b2b_valid", {31'd0, bus.valid}, 1);
            check_eq("b2b_data", {27'd0, bus.data}, sat(exp_words[k]));
            @(negedge clk);
            if (k < 2) bus.idx = 2'(k + 1);
            else bus.req = 1'b0;
        end
        @(posedge clk); #1;
        check_eq("b2b_valid_drop", {31'd0, bus.valid}, 0);
    endtask

    initial begin
        int n;
        int exp_seq [5];
        reset = 1'b1; enable = 1'b0; idle = 1'b0;
        bus.req = 1'b0; bus.idx = 2'd0;
        clear_model();

        // Reset state and empty run.
        do_reset();
        check_eq("rst_pops", {28'd0, bus.pop7, bus.pop6, bus.pop5, bus.pop4}, 0);
        check_eq("rst_data", {27'd0, bus.data}, 0);
        check_eq("rst_valid", {31'd0, bus.valid}, 0);
        check_eq("rst_err", {27'd0, err_cnt}, 0);
        check_eq("rst_done", {31'd0, done}, 0);
        enable = 1'b1; idle = 1'b1;
        wait_done(20, n);
        check_eq("empty_done_latency_ok", {31'd0, n <= 5}, 1);
        check_eq("empty_no_pops", pop_log.size(), 0);
        read_all();

        // FIFO4 x3, FIFO6 x2: alternation with exclusion.
        do_reset();
        load(0, 3, 0);
        load(2, 2, 0);
        enable = 1'b1; idle = 1'b1;
        wait_done(100, n);
        exp_seq = '{0, 2, 0, 2, 0};
        check_eq("alt_len", pop_log.size(), 5);
        for (int i = 0; i < 5 && i < pop_log.size(); i++)
            check_eq("alt_order", pop_log[i], exp_seq[i]);
        read_all();

        // Saturation on FIFO5.
        do_reset();
        load(1, 40, 0);
        enable = 1'b1; idle = 1'b1;
        wait_done(200, n);
        read_all();

        // Destination mismatch on FIFO7.
        do_reset();
        push_word(3, 10'b01_0000_0001);
        enable = 1'b1; idle = 1'b1;
        wait_done(50, n);
        read_all();

        // req during ACTIVE ignored; reset mid-run clears counts.
        do_reset();
        load(0, 10, 0);
        enable = 1'b1; idle = 1'b0; bus.req = 1'b1; bus.idx = 2'd0;
        n = 0;
        while (pop_cnt[0] < 5 && n < 100) begin
            @(negedge clk);
            n++;
            check_eq("valid_in_active", {31'd0, bus.valid}, 0);
        end
        check_eq("midrun_reached", {31'd0, pop_cnt[0] >= 5}, 1);
        reset = 1'b1; enable = 1'b0; bus.req = 1'b0;
        @(posedge clk); #1;
        check_eq("midrun_pops_off", {28'd0, bus.pop7, bus.pop6, bus.pop5, bus.pop4}, 0);
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        enable = 1'b1; idle = 1'b1;
        wait_done(20, n);
        read_one(0);

        // Randomized runs.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int k = 0; k < 4; k++) load(k, $urandom_range(0, 40), 20);
            enable = 1'b1;
            repeat ($urandom_range(0, 6)) @(negedge clk);
            idle = 1'b1;
            wait_done(500, n);
            read_b2b();
            read_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
